// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache and D-cache requests onto a single memory port.
// Optional ARB_ROUND_ROBIN_EN alternates contention winners; otherwise D has fixed priority.
`default_nettype none

module mem_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clrn,
  // I-cache side
  input  logic [31:0]      i_a,
  input  logic             i_strobe,
  output logic [31:0]      i_dout,
  output logic             i_ready,
  // D-cache side
  input  logic [31:0]      d_a,
  input  logic [31:0]      d_din,
  input  logic             d_rw,
  input  logic             d_strobe,
  output logic [31:0]      d_dout,
  output logic             d_ready,
  // memory side
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_din,
  output logic             mem_rw,
  output logic             mem_strobe,
  input  logic [31:0]      mem_dout,
  input  logic             mem_ready,
  // performance counters
  output logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] d_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic             gnt_i_w, gnt_d_w;
  logic             pick_d_w;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q: 0 = I-cache was granted last, 1 = D-cache was granted last
  logic last_q, last_d;

  always_comb begin
    pick_d_w = d_strobe & (~i_strobe | ~last_q);
  end
`else
  always_comb begin
    pick_d_w = d_strobe;
  end
`endif

  assign gnt_i_w = (state_q == GNT_I);
  assign gnt_d_w = (state_q == GNT_D);

  // Leaving a grant on either completion or cancellation keeps one IDLE
  // arbitration cycle between every pair of transfers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d_w) begin
          state_d = GNT_D;
        end else if (i_strobe) begin
          state_d = GNT_I;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I: begin
        if (!i_strobe || mem_ready) begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        if (!d_strobe || mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE) begin
      if (pick_d_w) begin
        last_d = 1'b1;
      end else if (i_strobe) begin
        last_d = 1'b0;
      end
    end
  end
`endif

  // Memory bus and cache responses are decoded from the registered grant so
  // that mem_ready/mem_dout reach the owning cache within the same cycle.
  always_comb begin
    mem_strobe = (gnt_i_w & i_strobe) | (gnt_d_w & d_strobe);
    mem_rw     = gnt_d_w & d_rw;
    mem_din    = gnt_d_w ? d_din : 32'h0;
    if (gnt_i_w) begin
      mem_a = i_a;
    end else if (gnt_d_w) begin
      mem_a = d_a;
    end else begin
      mem_a = 32'h0;
    end

    i_ready = gnt_i_w & i_strobe & mem_ready;
    d_ready = gnt_d_w & d_strobe & mem_ready;
    i_dout  = gnt_i_w ? mem_dout : 32'h0;
    d_dout  = gnt_d_w ? mem_dout : 32'h0;
  end

  always_comb begin
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    if (i_ready && (i_cnt_q != CNT_MAX)) begin
      i_cnt_d = i_cnt_q + CNT_ONE;
    end
    if (d_ready && (d_cnt_q != CNT_MAX)) begin
      d_cnt_d = d_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      i_cnt_q <= '0;
      d_cnt_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign i_cnt = i_cnt_q;
  assign d_cnt = d_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cache/memory stimulus with a queue scoreboard and a negedge monitor.
`default_nettype none

module tb_mem_arbiter;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clrn;
  logic [31:0]   i_a, d_a, d_din, mem_dout;
  logic          i_strobe, d_strobe, d_rw, mem_ready;
  logic [31:0]   i_dout, d_dout, mem_a, mem_din;
  logic          i_ready, d_ready, mem_rw, mem_strobe;
  logic [CW-1:0] i_cnt, d_cnt;

  mem_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .clrn(clrn),
    .i_a(i_a), .i_strobe(i_strobe), .i_dout(i_dout), .i_ready(i_ready),
    .d_a(d_a), .d_din(d_din), .d_rw(d_rw), .d_strobe(d_strobe),
    .d_dout(d_dout), .d_ready(d_ready),
    .mem_a(mem_a), .mem_din(mem_din), .mem_rw(mem_rw), .mem_strobe(mem_strobe),
    .mem_dout(mem_dout), .mem_ready(mem_ready),
    .i_cnt(i_cnt), .d_cnt(d_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic        rw;
    logic [31:0] din;
  } req_t;

  req_t i_q[$];
  req_t d_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mi = 0;
  int   md = 0;
  int   wait_cfg = 0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEADBEAF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory model: read data is a fixed function of the address; wait states
  // are counted from the first strobe cycle. Outside a strobe, ready and data are noise.
  initial begin
    int  wcnt;
    bit  active;
    active    = 0;
    wcnt      = 0;
    mem_ready = 1'b0;
    mem_dout  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!mem_strobe) begin
        active    = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_dout  = $urandom;
      end else begin
        if (!active) begin
          active = 1;
          wcnt   = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        end
        mem_ready = (wcnt == 0);
        mem_dout  = f(mem_a);
        if (wcnt > 0) wcnt--;
      end
    end
  end

  always @(negedge clrn) begin
    mi = 0;
    md = 0;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    req_t e;
    if (!clrn) begin
      chk("rst_mem_strobe", 32'(mem_strobe), 0);
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_rw", 32'(mem_rw), 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_ready", {30'b0, i_ready, d_ready}, 0);
      chk("rst_i_dout", i_dout, 0);
      chk("rst_d_dout", d_dout, 0);
      chk("rst_i_cnt", 32'(i_cnt), 0);
      chk("rst_d_cnt", 32'(d_cnt), 0);
    end else begin
      chk("i_cnt", 32'(i_cnt), 32'(mi));
      chk("d_cnt", 32'(d_cnt), 32'(md));
      chk("ready_excl", 32'(i_ready & d_ready), 0);
      if (!mem_strobe) chk("ready_wo_strobe", 32'(i_ready | d_ready), 0);
      if (i_ready) begin
        checks++;
        if (i_q.size() == 0) begin
          errors++;
          $display("FAIL i_unexpected_ready: got i_ready=1 expected no outstanding I request");
        end else begin
          e = i_q.pop_front();
          chk("i_dout", i_dout, f(e.a));
          chk("i_mem_a", mem_a, e.a);
          chk("i_mem_rw", 32'(mem_rw), 0);
          chk("i_mem_din", mem_din, 0);
          chk("i_other_dout", d_dout, 0);
          mi = (mi >= CMAX) ? CMAX : mi + 1;
        end
      end
      if (d_ready) begin
        checks++;
        if (d_q.size() == 0) begin
          errors++;
          $display("FAIL d_unexpected_ready: got d_ready=1 expected no outstanding D request");
        end else begin
          e = d_q.pop_front();
          chk("d_dout", d_dout, f(e.a));
          chk("d_mem_a", mem_a, e.a);
          chk("d_mem_rw", 32'(mem_rw), 32'(e.rw));
          chk("d_mem_din", mem_din, e.din);
          chk("d_other_dout", i_dout, 0);
          md = (md >= CMAX) ? CMAX : md + 1;
        end
      end
    end
  end

  // Both request tasks start at posedge+1 and return at the following posedge+1.
  task automatic do_i(input logic [31:0] a, input bit keep, output int cyc);
    req_t r;
    bit   got;
    r.a = a; r.rw = 1'b0; r.din = 32'h0;
    i_a = a; i_strobe = 1'b1;
    i_q.push_back(r);
    cyc = 0; got = 0;
    while (!got) begin
      @(negedge clk);
      if (i_ready) got = 1;
      else begin
        cyc++;
        if (cyc > 200) begin
          checks++; errors++;
          $display("FAIL i_timeout: got no i_ready expected completion within 200 cycles");
          void'(i_q.pop_back());
          keep = 0;
          break;
        end
      end
    end
    @(posedge clk); #1;
    if (!keep) i_strobe = 1'b0;
  endtask

  task automatic do_d(input logic [31:0] a, input logic rw, input logic [31:0] din, output int cyc);
    req_t r;
    bit   got;
    r.a = a; r.rw = rw; r.din = din;
    d_a = a; d_rw = rw; d_din = din; d_strobe = 1'b1;
    d_q.push_back(r);
    cyc = 0; got = 0;
    while (!got) begin
      @(negedge clk);
      if (d_ready) got = 1;
      else begin
        cyc++;
        if (cyc > 200) begin
          checks++; errors++;
          $display("FAIL d_timeout: got no d_ready expected completion within 200 cycles");
          void'(d_q.pop_back());
          break;
        end
      end
    end
    @(posedge clk); #1;
    d_strobe = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clrn = 1'b0; i_strobe = 1'b0; d_strobe = 1'b0;
    i_q.delete(); d_q.delete();
    @(posedge clk); #1;
    clrn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end within 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int       cyc, n, budget;
    bit       gi, gd, pend_i, pend_d;
    logic [3:0] seq, seq_exp;
    req_t     r;

    clrn = 1'b0; i_strobe = 1'b1; i_a = 32'h100;
    d_strobe = 1'b0; d_a = 0; d_din = 0; d_rw = 0;
    wait_cfg = 0;

    // Reset held with a pending I request; grant follows release
    repeat (3) @(posedge clk);
    #1;
    r.a = 32'h100; r.rw = 0; r.din = 0;
    i_q.push_back(r);
    clrn = 1'b1;
    @(negedge clk);
    chk("rel_idle_strobe", 32'(mem_strobe), 0);
    @(negedge clk);
    chk("rel_gnt_strobe", 32'(mem_strobe), 1);
    chk("rel_gnt_mem_a", mem_a, 32'h100);
    chk("rel_gnt_rw", 32'(mem_rw), 0);
    @(posedge clk); #1;
    i_strobe = 1'b0;

    // Zero-wait I read
    do_i(32'h40, 1, cyc);
    chk("i_zero_wait_lat", cyc, 1);
    @(negedge clk);
    chk("i_idle_after_strobe", 32'(mem_strobe), 0);
    chk("i_idle_after_ready", 32'(i_ready), 0);
    chk("i_idle_after_dout", i_dout, 0);
    @(posedge clk); #1;
    i_strobe = 1'b0;
    @(negedge clk);
    chk("i_cancel_strobe", 32'(mem_strobe), 0);
    @(posedge clk); #1;

    // D write with 3 wait cycles
    wait_cfg = 3;
    r.a = 32'h80; r.rw = 1; r.din = 32'h1234;
    d_q.push_back(r);
    d_a = 32'h80; d_din = 32'h1234; d_rw = 1'b1; d_strobe = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) chk("dw_c0_strobe", 32'(mem_strobe), 0);
      else begin
        chk("dw_rw", 32'(mem_rw), 1);
        chk("dw_din", mem_din, 32'h1234);
      end
      chk("dw_ready", 32'(d_ready), 32'(c == 4));
    end
    @(posedge clk); #1;
    d_strobe = 1'b0; d_rw = 1'b0;

    // Contention, zero-wait memory
    do_reset();
    wait_cfg = 0;
    i_a = 32'h200; d_a = 32'h300; d_rw = 1'b0; d_din = 32'h55;
    r.rw = 0; r.din = 0; r.a = i_a; i_q.push_back(r);
    r.din = d_din; r.a = d_a; d_q.push_back(r);
    i_strobe = 1'b1; d_strobe = 1'b1;
    pend_i = 1; pend_d = 1; n = 0; budget = 0; seq = 4'b0;
    while (n < 4 && budget < 40) begin
      @(negedge clk);
      budget++;
      gi = i_ready; gd = d_ready;
      if (gd) begin seq[n[1:0]] = 1'b1; n++; pend_d = 0; end
      if (gi && n < 4) begin seq[n[1:0]] = 1'b0; n++; pend_i = 0; end
      @(posedge clk); #1;
      if (n < 4) begin
        if (gd) begin d_a = d_a + 4; r.a = d_a; r.rw = 0; r.din = d_din; d_q.push_back(r); pend_d = 1; end
        if (gi) begin i_a = i_a + 4; r.a = i_a; r.rw = 0; r.din = 0; i_q.push_back(r); pend_i = 1; end
      end
    end
    i_strobe = 1'b0; d_strobe = 1'b0;
    if (pend_i) void'(i_q.pop_back());
    if (pend_d) void'(d_q.pop_back());
`ifdef ARB_ROUND_ROBIN_EN
    seq_exp = 4'b0101;
`else
    seq_exp = 4'b1111;
`endif
    chk("contention_count", n, 4);
    chk("contention_order", 32'(seq), 32'(seq_exp));

    // Abort an I grant while D is waiting
    wait_cfg = 5;
    r.a = 32'h500; r.rw = 0; r.din = 0; i_q.push_back(r);
    i_a = 32'h500; i_strobe = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    r.a = 32'h600; r.rw = 0; r.din = 32'h77; d_q.push_back(r);
    d_a = 32'h600; d_rw = 1'b0; d_din = 32'h77; d_strobe = 1'b1;
    @(negedge clk);
    chk("abort_gnt_strobe", 32'(mem_strobe), 1);
    chk("abort_gnt_mem_a", mem_a, 32'h500);
    @(posedge clk); #1;
    i_strobe = 1'b0;
    void'(i_q.pop_back());
    @(negedge clk);
    chk("abort_drop_strobe", 32'(mem_strobe), 0);
    @(posedge clk); #1;
    wait_cfg = 0;
    @(negedge clk);
    chk("abort_idle_strobe", 32'(mem_strobe), 0);
    @(negedge clk);
    chk("abort_d_gnt_strobe", 32'(mem_strobe), 1);
    chk("abort_d_gnt_mem_a", mem_a, 32'h600);
    chk("abort_d_ready", 32'(d_ready), 1);
    @(posedge clk); #1;
    d_strobe = 1'b0;

    // Asynchronous reset in the middle of a D transfer
    wait_cfg = 5;
    r.a = 32'h700; r.rw = 1; r.din = 32'h99; d_q.push_back(r);
    d_a = 32'h700; d_rw = 1'b1; d_din = 32'h99; d_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_strobe", 32'(mem_strobe), 1);
    #1;
    clrn = 1'b0;
    #1;
    chk("arst_strobe_drop", 32'(mem_strobe), 0);
    chk("arst_mem_a", mem_a, 0);
    d_strobe = 1'b0; d_rw = 1'b0;
    void'(d_q.pop_back());
    @(posedge clk); #1;
    clrn = 1'b1;

    // Counter saturation
    do_reset();
    wait_cfg = 0;
    for (int k = 0; k < 17; k++) do_i(32'h1000 + 32'(k * 4), 0, cyc);
    chk("i_cnt_saturated", 32'(i_cnt), CMAX);

    // Randomised traffic from both caches
    do_reset();
    wait_cfg = -1;
    fork
      begin
        int c1;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_i($urandom & 32'hFFFC, 0, c1);
        end
      end
      begin
        int c2;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_d($urandom & 32'hFFFC, 1'($urandom_range(0, 1)), $urandom, c2);
        end
      end
    join

    repeat (3) @(posedge clk);
    chk("i_q_drained", i_q.size(), 0);
    chk("d_q_drained", d_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
